// File: rtl/serial_subtractor_pkg.sv
// serial_sub_pkg: shared state encoding and default operand width for the
// bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit combinational subtractor cell, d = a - b - bin.
// Used as the single arithmetic cell of serial_subtractor and usable on its own.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out of a single bit position.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b, LSB first,
// one full_subtractor cell reused every cycle. One result per WIDTH+2 cycles.
// Optional signed-overflow output ovf is built when SERIAL_SUB_OVERFLOW_EN
// is defined.
//
//   state | meaning
//   IDLE  | waiting for start; results held
//   SHIFT | one operand bit pair processed per edge
//   DONE  | diff/borrow valid, done pulses for one cycle
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             bin;
  logic [CW-1:0]    cnt;
  logic             cell_d, cell_bout;
  logic             last_bit;
  logic             accept;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bin),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = (state == IDLE) && start;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand/result shift registers, running borrow and bit counter.
  // The counter holds on the last bit so it never wraps for power-of-two widths.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      bin    <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      bin    <= 1'b0;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {cell_d, res_sr[WIDTH-1:1]};
      bin    <= cell_bout;
      if (!last_bit) cnt <= cnt + 1'b1;
    end
  end

  // Result registers, updated only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff   <= '0;
      borrow <= 1'b0;
    end else if ((state == SHIFT) && last_bit) begin
      diff   <= {cell_d, res_sr[WIDTH-1:1]};
      borrow <= cell_bout;
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb, b_msb;

  // Captured operand sign bits and signed overflow; the last cell output is diff's MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if ((state == SHIFT) && last_bit) begin
      ovf <= (a_msb ^ b_msb) & (cell_d ^ a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: self-checking bench for serial_subtractor (WIDTH=8 and
// WIDTH=4 instances) and the standalone full_subtractor cell. Checks ovf when
// SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8, diff8;
  logic       busy8, done8, borrow8;
  logic [3:0] a4, b4, diff4;
  logic       busy4, done4, borrow4;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       ovf8, ovf4;
`endif
  logic       fs_a, fs_b, fs_bin, fs_d, fs_bout;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] prev_diff;
  logic       prev_borrow;
  logic       prev_ovf;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .ovf(ovf4)
`endif
  );

  full_subtractor u_fs (.a(fs_a), .b(fs_b), .bin(fs_bin), .d(fs_d), .bout(fs_bout));

  function automatic logic model_ovf8(input int x, input int y);
    int sx, sy, r;
    sx = (x >= 128) ? x - 256 : x;
    sy = (y >= 128) ? y - 256 : y;
    r  = sx - sy;
    return (r > 127) || (r < -128);
  endfunction

  task automatic test_full_subtractor();
    int r;
    for (int i = 0; i < 8; i++) begin
      fs_a   = i[2];
      fs_b   = i[1];
      fs_bin = i[0];
      #1;
      r = int'(fs_a) - int'(fs_b) - int'(fs_bin);
      n_tests++;
      if (fs_d !== r[0] || fs_bout !== (r < 0)) begin
        n_fail++;
        $display("FAIL cell a=%0d b=%0d bin=%0d: got d=%b bout=%b, want d=%b bout=%b",
                 fs_a, fs_b, fs_bin, fs_d, fs_bout, r[0], (r < 0));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b1; start4 = 1'b1; a8 = 8'hFF; b8 = 8'h01; a4 = 4'h3; b4 = 4'h1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || borrow8 !== 1'b0 ||
        busy4 !== 1'b0 || done4 !== 1'b0 || diff4 !== 4'h0 || borrow4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got busy=%b done=%b diff=%h borrow=%b / busy4=%b done4=%b diff4=%h borrow4=%b, want all zero",
               busy8, done8, diff8, borrow8, busy4, done4, diff4, borrow4);
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    n_tests++;
    if (ovf8 !== 1'b0 || ovf4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b/%b, want 0/0", ovf8, ovf4);
    end
`endif
    start8 = 1'b0; start4 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    prev_diff = 8'h00; prev_borrow = 1'b0; prev_ovf = 1'b0;
  endtask

  // One complete WIDTH=8 operation starting from IDLE, with operands scrambled after accept.
  task automatic run_op(input int oa, input int ob);
    int         cycles, busy_cnt;
    bit         held_ok;
    logic [7:0] ed;
    logic       eb, eo;
    ed = 8'(oa - ob);
    eb = (oa < ob);
    eo = model_ovf8(oa, ob);
    a8 = 8'(oa); b8 = 8'(ob); start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    cycles = 0; busy_cnt = 0; held_ok = 1'b1;
    while (!done8 && cycles < 40) begin
      if (busy8) busy_cnt++;
      if (diff8 !== prev_diff || borrow8 !== prev_borrow) held_ok = 1'b0;
      @(negedge clk);
      cycles++;
    end
    n_tests++;
    if (cycles != 8 || busy_cnt != 8) begin
      n_fail++;
      $display("FAIL latency %h-%h: got done after %0d cycles busy %0d, want 8/8", oa, ob, cycles, busy_cnt);
    end
    n_tests++;
    if (!held_ok) begin
      n_fail++;
      $display("FAIL hold %h-%h: diff/borrow changed during SHIFT, want %h/%b held", oa, ob, prev_diff, prev_borrow);
    end
    n_tests++;
    if (diff8 !== ed || borrow8 !== eb || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL result %h-%h: got diff=%h borrow=%b busy=%b, want diff=%h borrow=%b busy=0",
               oa, ob, diff8, borrow8, busy8, ed, eb);
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    n_tests++;
    if (ovf8 !== eo) begin
      n_fail++;
      $display("FAIL ovf %h-%h: got %b, want %b", oa, ob, ovf8, eo);
    end
`endif
    @(negedge clk);
    n_tests++;
    if (done8 !== 1'b0 || diff8 !== ed) begin
      n_fail++;
      $display("FAIL done_pulse %h-%h: got done=%b diff=%h, want done=0 diff=%h", oa, ob, done8, diff8, ed);
    end
    prev_diff = ed; prev_borrow = eb; prev_ovf = eo;
  endtask

  task automatic test_directed();
    run_op(8'h05, 8'h03);
    run_op(8'h03, 8'h05);
    run_op(8'h00, 8'h00);
    run_op(8'h80, 8'h01);
    run_op(8'h7F, 8'h01);
    run_op(8'hFF, 8'hFF);
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      run_op(int'($urandom_range(255)), int'($urandom_range(255)));
      repeat ($urandom_range(2)) @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    int done_cnt, first_done;
    a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    done_cnt = 0; first_done = -1;
    for (int i = 1; i <= 14; i++) begin
      if (i == 3) begin start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; end
      if (i == 4) start8 = 1'b0;
      @(negedge clk);
      if (done8) begin
        done_cnt++;
        if (first_done < 0) first_done = i;
      end
    end
    n_tests++;
    if (done_cnt != 1 || first_done != 8 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start: got %0d done pulses first at %0d busy=%b, want 1 at 8 busy=0",
               done_cnt, first_done, busy8);
    end
    n_tests++;
    if (diff8 !== 8'hFE || borrow8 !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start_result: got diff=%h borrow=%b, want FE/0", diff8, borrow8);
    end
    prev_diff = 8'hFE; prev_borrow = 1'b0; prev_ovf = model_ovf8(8'hFF, 8'h01);
  endtask

  task automatic test_mid_reset();
    a8 = 8'h5A; b8 = 8'hC3; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || borrow8 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b done=%b diff=%h borrow=%b, want 0/0/00/0", busy8, done8, diff8, borrow8);
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    n_tests++;
    if (ovf8 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_ovf: got %b, want 0", ovf8);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    prev_diff = 8'h00; prev_borrow = 1'b0; prev_ovf = 1'b0;
    run_op(8'h10, 8'h01);
  endtask

  // All 256 WIDTH=4 pairs with start held high, so each accept follows the previous done.
  task automatic test_back_to_back();
    int idx, last, cyc;
    logic [3:0] ed;
    logic       eb;
    idx = 0; last = -1; cyc = 0;
    a4 = 4'h0; b4 = 4'h0; start4 = 1'b1;
    while (idx < 256 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (done4) begin
        ed = 4'(int'(a4) - int'(b4));
        ed = 4'((idx / 16) - (idx % 16));
        eb = ((idx / 16) < (idx % 16));
        n_tests++;
        if (diff4 !== ed || borrow4 !== eb) begin
          n_fail++;
          $display("FAIL sweep %h-%h: got diff=%h borrow=%b, want %h/%b", idx / 16, idx % 16, diff4, borrow4, ed, eb);
        end
        if (last >= 0) begin
          n_tests++;
          if (cyc - last != 6) begin
            n_fail++;
            $display("FAIL spacing pair %0d: got %0d cycles, want 6", idx, cyc - last);
          end
        end
        last = cyc;
        idx++;
        a4 = 4'(idx / 16);
        b4 = 4'(idx % 16);
      end
    end
    start4 = 1'b0;
    n_tests++;
    if (idx != 256) begin
      n_fail++;
      $display("FAIL sweep_timeout: got %0d results, want 256", idx);
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a4 = 4'h0; b4 = 4'h0;
    fs_a = 1'b0; fs_b = 1'b0; fs_bin = 1'b0;
    prev_diff = 8'h00; prev_borrow = 1'b0; prev_ovf = 1'b0;
    test_full_subtractor();
    test_reset();
    test_directed();
    test_start_ignored();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
